// File: rtl/psram_pkg.sv
// Shared definitions for the APS6404-class SPI PSRAM controller:
// command opcodes, expected EID bytes, page geometry and FSM state encoding.
package psram_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_RSTEN = 8'h66;
   localparam logic [7:0] CMD_RST   = 8'h99;
   localparam logic [7:0] CMD_RDID  = 8'h9F;

   localparam logic [7:0] EID_MFR   = 8'h0D;
   localparam logic [7:0] EID_KGD   = 8'h5D;

   localparam int PAGE_SIZE = 1024;
   localparam int PAGE_W    = $clog2(PAGE_SIZE);

   typedef enum logic [3:0] {
      S_POR_WAIT,
      S_RSTEN,
      S_GAP,
      S_RST,
      S_RDID,
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_PAGE_GAP,
      S_END_GAP
   } state_t;

endpackage

// File: rtl/psram_spi_byte.sv
// SPI mode-0 byte shifter, MSB first, CLK_DIV sysclk cycles per half-period.
// Ports: start/din load a byte (also back-to-back in the done cycle);
// done is high in the last cycle of a byte, when dout holds the received byte;
// busy while shifting; spiclk/mosi/miso are the serial pins.
module psram_spi_byte #(
   parameter int CLK_DIV = 4
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       busy,
   output logic       done,
   output logic       spiclk,
   output logic       mosi,
   input  logic       miso
);

   localparam int DW = $clog2(CLK_DIV);

   logic [DW-1:0] div_q;
   logic [3:0]    half_q;
   logic [7:0]    tx_q;
   logic [7:0]    rx_q;
   logic          busy_q;
   logic          sck_q;
   logic          tick;

   assign tick   = busy_q && (div_q == DW'(CLK_DIV - 1));
   // last cycle of the final high phase: the falling edge ends the byte
   assign done   = tick && (half_q == 4'd15);
   assign busy   = busy_q;
   assign dout   = rx_q;
   assign spiclk = sck_q;
   assign mosi   = busy_q & tx_q[7];

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         div_q  <= '0;
         half_q <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
         busy_q <= 1'b0;
         sck_q  <= 1'b0;
      end else if (start) begin
         busy_q <= 1'b1;
         div_q  <= '0;
         half_q <= '0;
         tx_q   <= din;
         sck_q  <= 1'b0;
      end else if (busy_q) begin
         if (tick) begin
            div_q  <= '0;
            half_q <= half_q + 4'd1;
            if (!half_q[0]) begin
               sck_q <= 1'b1;
               rx_q  <= {rx_q[6:0], miso};
            end else begin
               sck_q <= 1'b0;
               tx_q  <= {tx_q[6:0], 1'b0};
               if (half_q == 4'd15) busy_q <= 1'b0;
            end
         end else begin
            div_q <= div_q + DW'(1);
         end
      end
   end

endmodule

// File: rtl/psram_spi_ctrl.sv
// SPI PSRAM controller: power-up wait, reset-enable/reset, EID read, then
// single/burst read/write requests split at 1 KB page boundaries.
// Ports: req_* request handshake; wr_data/wr_ready write byte feed;
// rd_data/rd_valid read byte stream; done per request; init_done/id_ok/eid
// init status; spiclk/mosi/miso/ce_q_ device pins.
module psram_spi_ctrl
   import psram_pkg::*;
#(
   parameter int CLK_DIV        = 4,
   parameter int POWERON_CYCLES = 7500,
   parameter int CS_GAP         = 8,
   parameter int MAX_BURST      = 32,
   parameter int ADDR_W         = 23,
   localparam int LEN_W         = $clog2(MAX_BURST)
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [7:0]        wr_data,
   output logic              wr_ready,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              init_done,
   output logic              id_ok,
   output logic [63:0]       eid,
   output logic              spiclk,
   output logic              mosi,
   input  logic              miso,
   output logic              ce_q_
);

   localparam int GAP_END = CLK_DIV + CS_GAP - 1;
   localparam int CW = $clog2(POWERON_CYCLES + CLK_DIV + CS_GAP + 1);

   state_t            state_q, state_n, ret_q, ret_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic [3:0]        bidx_q, bidx_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [LEN_W-1:0]  left_q, left_n;
   logic              write_q, write_n;
   logic [63:0]       eid_q, eid_n;
   logic              ce_q, ce_n;
   logic [7:0]        rdd_q, rdd_n;
   logic              rdv_q, rdv_n;
   logic              done_q, done_n;
   logic              ready_q, ready_n;
   logic              init_q, init_n;
   logic              idok_q, idok_n;

   logic              start;
   logic [7:0]        din;
   logic [7:0]        cmd;
   logic [23:0]       a24;
   logic [7:0]        sh_dout;
   logic              sh_done;
   logic              sh_busy;

   psram_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .start  (start),
      .din    (din),
      .dout   (sh_dout),
      .busy   (sh_busy),
      .done   (sh_done),
      .spiclk (spiclk),
      .mosi   (mosi),
      .miso   (miso)
   );

   assign a24       = 24'(addr_q);
   assign cmd       = write_q ? CMD_WRITE : CMD_READ;
   assign req_ready = ready_q;
   assign rd_data   = rdd_q;
   assign rd_valid  = rdv_q;
   assign done      = done_q;
   assign init_done = init_q;
   assign id_ok     = idok_q;
   assign eid       = eid_q;
   assign ce_q_     = ce_q;

   always_comb begin
      state_n  = state_q;
      ret_n    = ret_q;
      cnt_n    = cnt_q;
      bidx_n   = bidx_q;
      addr_n   = addr_q;
      left_n   = left_q;
      write_n  = write_q;
      eid_n    = eid_q;
      ce_n     = ce_q;
      rdd_n    = rdd_q;
      rdv_n    = 1'b0;
      done_n   = 1'b0;
      ready_n  = ready_q;
      init_n   = init_q;
      idok_n   = idok_q;
      start    = 1'b0;
      din      = 8'h00;
      wr_ready = 1'b0;
      unique case (state_q)
         S_POR_WAIT: begin
            if (cnt_q == CW'(POWERON_CYCLES - 1)) begin
               start   = 1'b1;
               din     = CMD_RSTEN;
               ce_n    = 1'b0;
               cnt_n   = '0;
               state_n = S_RSTEN;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         S_RSTEN, S_RST: begin
            if (sh_done) begin
               ret_n   = (state_q == S_RSTEN) ? S_RST : S_RDID;
               cnt_n   = '0;
               state_n = S_GAP;
            end
         end
         // CE stays low CLK_DIV cycles after the last falling edge,
         // then high for CS_GAP cycles before the next step
         S_GAP, S_PAGE_GAP, S_END_GAP: begin
            cnt_n = cnt_q + CW'(1);
            if (cnt_q == CW'(CLK_DIV - 1)) ce_n = 1'b1;
            if (cnt_q == CW'(GAP_END)) begin
               cnt_n = '0;
               if (state_q == S_PAGE_GAP) begin
                  start   = 1'b1;
                  din     = cmd;
                  ce_n    = 1'b0;
                  state_n = S_CMD;
               end else if (state_q == S_END_GAP) begin
                  done_n  = 1'b1;
                  ready_n = 1'b1;
                  state_n = S_IDLE;
               end else if (ret_q == S_IDLE) begin
                  init_n  = 1'b1;
                  idok_n  = (eid_q[63:56] == EID_MFR) &&
                            (eid_q[55:48] == EID_KGD);
                  ready_n = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  start   = 1'b1;
                  din     = (ret_q == S_RST) ? CMD_RST : CMD_RDID;
                  ce_n    = 1'b0;
                  bidx_n  = '0;
                  state_n = ret_q;
               end
            end
         end
         // byte 0 opcode, 1..3 zero address, 4..11 EID
         S_RDID: begin
            if (sh_done) begin
               bidx_n = bidx_q + 4'd1;
               if (bidx_q >= 4'd4) eid_n = {eid_q[55:0], sh_dout};
               if (bidx_q == 4'd11) begin
                  ret_n   = S_IDLE;
                  cnt_n   = '0;
                  state_n = S_GAP;
               end else begin
                  start = 1'b1;
               end
            end
         end
         S_IDLE: begin
            if (req_valid && ready_q) begin
               write_n = req_write;
               addr_n  = req_addr;
               left_n  = req_len;
               ready_n = 1'b0;
               ce_n    = 1'b0;
               start   = 1'b1;
               din     = req_write ? CMD_WRITE : CMD_READ;
               state_n = S_CMD;
            end
         end
         S_CMD: begin
            if (sh_done) begin
               start   = 1'b1;
               din     = a24[23:16];
               bidx_n  = 4'd1;
               state_n = S_ADDR;
            end
         end
         S_ADDR: begin
            if (sh_done) begin
               start  = 1'b1;
               bidx_n = bidx_q + 4'd1;
               if (bidx_q == 4'd1) begin
                  din = a24[15:8];
               end else if (bidx_q == 4'd2) begin
                  din = a24[7:0];
               end else begin
                  din      = write_q ? wr_data : 8'h00;
                  wr_ready = write_q;
                  state_n  = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (sh_done) begin
               if (!write_q) begin
                  rdd_n = sh_dout;
                  rdv_n = 1'b1;
               end
               addr_n = addr_q + ADDR_W'(1);
               if (left_q == '0) begin
                  cnt_n   = '0;
                  state_n = S_END_GAP;
               end else begin
                  left_n = left_q - LEN_W'(1);
                  // top of a page (or of the address space): new frame
                  if (&addr_q[PAGE_W-1:0]) begin
                     cnt_n   = '0;
                     state_n = S_PAGE_GAP;
                  end else begin
                     start    = 1'b1;
                     din      = write_q ? wr_data : 8'h00;
                     wr_ready = write_q;
                  end
               end
            end
         end
         default: state_n = S_POR_WAIT;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state_q <= S_POR_WAIT;
         ret_q   <= S_RST;
         cnt_q   <= '0;
         bidx_q  <= '0;
         addr_q  <= '0;
         left_q  <= '0;
         write_q <= 1'b0;
         eid_q   <= '0;
         ce_q    <= 1'b1;
         rdd_q   <= '0;
         rdv_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         init_q  <= 1'b0;
         idok_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         ret_q   <= ret_n;
         cnt_q   <= cnt_n;
         bidx_q  <= bidx_n;
         addr_q  <= addr_n;
         left_q  <= left_n;
         write_q <= write_n;
         eid_q   <= eid_n;
         ce_q    <= ce_n;
         rdd_q   <= rdd_n;
         rdv_q   <= rdv_n;
         done_q  <= done_n;
         ready_q <= ready_n;
         init_q  <= init_n;
         idok_q  <= idok_n;
      end
   end

endmodule

// File: tb/tb_psram_spi_ctrl.sv
// Bench for psram_spi_ctrl: SPI PSRAM device model plus scoreboards for
// frames on mosi, read data, write strobes and done.
module tb_psram_spi_ctrl;

   localparam int CLK_DIV        = 4;
   localparam int POWERON_CYCLES = 7500;
   localparam int CS_GAP         = 8;
   localparam int MAX_BURST      = 32;
   localparam int ADDR_W         = 23;
   localparam int LEN_W          = $clog2(MAX_BURST);
   localparam int AMASK          = (1 << ADDR_W) - 1;
   localparam int TMO            = 20000;

   logic              sysclk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [LEN_W-1:0]  req_len = '0;
   logic [7:0]        wr_data = 8'h00;
   logic              wr_ready;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic              done;
   logic              init_done;
   logic              id_ok;
   logic [63:0]       eid;
   logic              spiclk;
   logic              mosi;
   logic              miso = 1'b0;
   logic              ce_q_;

   psram_spi_ctrl #(
      .CLK_DIV(CLK_DIV), .POWERON_CYCLES(POWERON_CYCLES),
      .CS_GAP(CS_GAP), .MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W)
   ) dut (
      .sysclk(sysclk), .rst_n(rst_n), .req_valid(req_valid),
      .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .req_len(req_len), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
      .init_done(init_done), .id_ok(id_ok), .eid(eid),
      .spiclk(spiclk), .mosi(mosi), .miso(miso), .ce_q_(ce_q_)
   );

   always #5 sysclk = ~sysclk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge sysclk) cyc++;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int a);
      logic [31:0] v;
      v = a;
      return v[7:0] ^ v[15:8] ^ 8'h5A;
   endfunction

   // ---------------- PSRAM device model ----------------
   logic [7:0] dev_mem [int];
   logic [7:0] eid_m [8];
   logic [7:0] fr [$];
   logic [7:0] sh = 8'h00;
   int         bitcnt = 0;
   int         faddr = 0;
   int         last_rise = -1;
   int         first_fall = -1;

   always @(negedge ce_q_) begin
      bitcnt = 0;
      fr.delete();
      if (first_fall < 0) first_fall = cyc;
      if (last_rise >= 0) begin
         checks++;
         if (cyc - last_rise < CS_GAP) begin
            errors++;
            $display("FAIL cs_gap: got %0d cycles expected >= %0d",
                     cyc - last_rise, CS_GAP);
         end
      end
   end

   always @(posedge spiclk) begin
      if (ce_q_ === 1'b0) begin
         sh = {sh[6:0], mosi};
         bitcnt++;
         if (bitcnt % 8 == 0) begin
            fr.push_back(sh);
            if (fr.size() == 4)
               faddr = int'({fr[1], fr[2], fr[3]}) & AMASK;
            else if (fr.size() > 4 && fr[0] == 8'h02)
               dev_mem[(faddr + fr.size() - 5) & AMASK] = sh;
         end
      end
   end

   always @(negedge spiclk) begin : dev_out
      int k;
      int a;
      logic [7:0] b;
      if (ce_q_ === 1'b0 && bitcnt >= 32) begin
         k = (bitcnt - 32) / 8;
         b = 8'h00;
         if (fr[0] == 8'h03) begin
            a = (faddr + k) & AMASK;
            b = dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
         end else if (fr[0] == 8'h9F && k < 8) begin
            b = eid_m[k];
         end
         miso = b[3'(7 - bitcnt % 8)];
      end
   end

   // ---------------- scoreboards ----------------
   int         exp_len [$];
   logic [7:0] exp_bytes [$];
   logic [7:0] exp_rd [$];
   logic [7:0] ref_mem [int];
   logic [7:0] wq [$];
   int         exp_done = 0;
   int         done_seen = 0;
   int         wr_cnt = 0;
   bit         wr_pend = 0;
   bit         ignore_frames = 0;

   always @(posedge ce_q_) begin : frame_mon
      int n;
      bit ok;
      string sa;
      string se;
      logic [7:0] e;
      if (fr.size() > 0) begin
         last_rise = cyc;
         if (!ignore_frames) begin
            checks++;
            if (exp_len.size() == 0) begin
               errors++;
               $display("FAIL frame: got %0d bytes expected no frame",
                        fr.size());
            end else begin
               n = exp_len.pop_front();
               ok = (fr.size() == n);
               sa = "";
               se = "";
               for (int i = 0; i < n; i++) begin
                  e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'h00;
                  se = {se, $sformatf(" %h", e)};
                  if (i < fr.size() && fr[i] !== e) ok = 0;
               end
               foreach (fr[i]) sa = {sa, $sformatf(" %h", fr[i])};
               if (!ok) begin
                  errors++;
                  $display("FAIL frame: got%s expected%s", sa, se);
               end
            end
         end
      end
   end

   always @(negedge sysclk) begin
      if (rd_valid) begin
         if (exp_rd.size() == 0) check("rd_unexpected", 64'(rd_valid), 0);
         else check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
      end
      if (done) begin
         done_seen++;
         checks++;
         if (exp_done == 0) begin
            errors++;
            $display("FAIL done: got unexpected strobe expected none");
         end else begin
            exp_done--;
         end
      end
      if (wr_pend) begin
         if (wq.size() != 0) void'(wq.pop_front());
         wr_pend = 0;
      end
      wr_data = (wq.size() != 0) ? wq[0] : 8'h00;
      if (wr_ready) begin
         wr_cnt++;
         if (wq.size() == 0) check("wr_unexpected", 64'(wr_ready), 0);
         wr_pend = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic expect_req(input bit w, input int addr, input int n,
                             input bit rnd, input logic [7:0] base);
      int a;
      int flen;
      logic [7:0] d;
      flen = 0;
      for (int i = 0; i < n; i++) begin
         a = (addr + i) & AMASK;
         if (i == 0 || a % 1024 == 0) begin
            if (i > 0) exp_len.push_back(flen);
            exp_bytes.push_back(w ? 8'h02 : 8'h03);
            exp_bytes.push_back(8'(a >> 16));
            exp_bytes.push_back(8'(a >> 8));
            exp_bytes.push_back(8'(a));
            flen = 4;
         end
         if (w) begin
            d = rnd ? 8'($urandom) : base + 8'(i);
            wq.push_back(d);
            ref_mem[a] = d;
            exp_bytes.push_back(d);
         end else begin
            exp_bytes.push_back(8'h00);
            exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : init_byte(a));
         end
         flen++;
      end
      exp_len.push_back(flen);
      exp_done++;
   endtask

   task automatic send(input bit w, input int addr, input int n);
      int t;
      t = 0;
      @(negedge sysclk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = ADDR_W'(addr);
      req_len   = LEN_W'(n - 1);
      while (!req_ready && t < TMO) begin
         @(negedge sysclk);
         t++;
      end
      if (t >= TMO) begin
         check("accept_timeout", 64'(req_ready), 1);
         req_valid = 1'b0;
      end else begin
         @(posedge sysclk);
         #1 req_valid = 1'b0;
         @(negedge sysclk);
         check("ready_drop", 64'(req_ready), 0);
      end
   endtask

   task automatic run_req(input bit w, input int addr, input int n,
                          input bit rnd, input logic [7:0] base);
      int t;
      int target;
      target = done_seen + 1;
      expect_req(w, addr, n, rnd, base);
      send(w, addr, n);
      t = 0;
      while (done_seen < target && t < TMO) begin
         @(negedge sysclk);
         t++;
      end
      if (t >= TMO) check("done_timeout", 64'(done_seen), 64'(target));
      check("wr_left", 64'(wq.size()), 0);
      check("rd_left", 64'(exp_rd.size()), 0);
   endtask

   task automatic push_init_frames();
      exp_len.push_back(1);
      exp_bytes.push_back(8'h66);
      exp_len.push_back(1);
      exp_bytes.push_back(8'h99);
      exp_len.push_back(12);
      exp_bytes.push_back(8'h9F);
      for (int i = 0; i < 11; i++) exp_bytes.push_back(8'h00);
   endtask

   task automatic wait_init(input logic [63:0] exp_eid, input bit exp_ok,
                            input int rel_cyc);
      int t;
      t = 0;
      while (!init_done && t < TMO * 2) begin
         @(negedge sysclk);
         t++;
      end
      check("init_done", 64'(init_done), 1);
      check("eid", eid, exp_eid);
      check("id_ok", 64'(id_ok), 64'(exp_ok));
      checks++;
      if (first_fall - rel_cyc < POWERON_CYCLES) begin
         errors++;
         $display("FAIL por_wait: got %0d cycles expected >= %0d",
                  first_fall - rel_cyc, POWERON_CYCLES);
      end
      check("ready_after_init", 64'(req_ready), 1);
   endtask

   initial begin : main
      int rel;
      int a;
      int n;
      int w0;
      eid_m = '{8'h0D, 8'h5D, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      repeat (3) @(negedge sysclk);
      check("rst_ce", 64'(ce_q_), 1);
      check("rst_sck_mosi", 64'({spiclk, mosi}), 0);
      check("rst_strobes", 64'({req_ready, wr_ready, rd_valid, done}), 0);
      check("rst_init", 64'({init_done, id_ok}), 0);
      check("rst_eid", eid, 0);
      check("rst_rd_data", 64'(rd_data), 0);

      push_init_frames();
      rel = cyc;
      rst_n = 1'b1;
      wait_init(64'h0D5D112233445566, 1'b1, rel);

      run_req(1'b1, 'h000100, 4, 1'b0, 8'hA0);
      run_req(1'b0, 'h000100, 4, 1'b0, 8'h00);
      run_req(1'b1, 'h0003FE, 4, 1'b1, 8'h00);
      run_req(1'b0, 'h0003FE, 4, 1'b0, 8'h00);
      run_req(1'b0, 'h7FFFFF, 2, 1'b0, 8'h00);
      run_req(1'b1, 'h7FFFFE, 3, 1'b1, 8'h00);
      run_req(1'b0, 'h7FFFFE, 3, 1'b0, 8'h00);

      for (int i = 0; i < 8; i++) begin
         a = int'($urandom) & AMASK;
         if ($urandom_range(0, 1) == 1)
            a = ((a | 'h3FF) - int'($urandom_range(0, 6))) & AMASK;
         n = int'($urandom_range(1, MAX_BURST));
         run_req(1'b1, a, n, 1'b1, 8'h00);
         if ($urandom_range(0, 1) == 1) run_req(1'b0, a, n, 1'b0, 8'h00);
         else run_req(1'b0, (a + 5) & AMASK, n, 1'b0, 8'h00);
      end

      // reset in the middle of the 2nd data byte of a write
      ignore_frames = 1;
      for (int i = 0; i < 4; i++) wq.push_back(8'hC0 + 8'(i));
      w0 = wr_cnt;
      send(1'b1, 'h005000, 4);
      n = 0;
      while (wr_cnt < w0 + 2 && n < TMO) begin
         @(negedge sysclk);
         n++;
      end
      check("abort_reach", 64'(wr_cnt), 64'(w0 + 2));
      repeat (10) @(negedge sysclk);
      rst_n = 1'b0;
      @(negedge sysclk);
      check("abort_ce", 64'(ce_q_), 1);
      check("abort_sck", 64'(spiclk), 0);
      check("abort_flags", 64'({req_ready, done, init_done, rd_valid}), 0);
      check("abort_eid", eid, 0);
      wq.delete();
      wr_pend = 0;
      exp_rd.delete();
      exp_len.delete();
      exp_bytes.delete();
      exp_done = 0;
      w0 = done_seen;
      eid_m[0] = 8'h00;
      first_fall = -1;
      repeat (3) @(negedge sysclk);
      push_init_frames();
      ignore_frames = 0;
      rel = cyc;
      rst_n = 1'b1;
      wait_init(64'h005D112233445566, 1'b0, rel);
      check("abort_no_done", 64'(done_seen), 64'(w0));

      run_req(1'b0, 'h000100, 4, 1'b0, 8'h00);

      repeat (50) @(negedge sysclk);
      check("frames_left", 64'(exp_len.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/psram_spi_ctrl.md
# psram_spi_ctrl

Parametrised SPI-mode controller for an APS6404-class 64 Mbit PSRAM. After power-up it waits out the device power-on time, issues the reset-enable/reset pair and reads the 8-byte EID. It then serves single or burst read/write requests from one requester over a valid/ready request port, splitting bursts transparently at 1 KB page boundaries. It sits between the system fabric and the PSRAM pins (spiclk, mosi, miso, ce_q_).

## Interface
- CLK_DIV, 4: sysclk cycles per spiclk half-period (≥2); one byte = 16·CLK_DIV cycles.
- POWERON_CYCLES, 7500: sysclk cycles of CE high/SCK low after reset (150 µs at 50 MHz).
- CS_GAP, 8: minimum sysclk cycles ce_q_ stays high between frames.
- MAX_BURST, 32: maximum bytes per request (power of two).
- ADDR_W, 23: byte address width.
- sysclk  in  1  system clock; one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and initialised.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start byte address.
- req_len  in  $clog2(MAX_BURST)  byte count minus one.
- wr_data  in  8  write byte, sampled in the cycle wr_ready is high.
- wr_ready  out  1  one-cycle strobe: wr_data consumed.
- rd_data  out  8  read byte, valid while rd_valid is high.
- rd_valid  out  1  one-cycle strobe per received byte.
- done  out  1  one-cycle strobe: request complete, CE released.
- init_done  out  1  init sequence finished; stays high until reset.
- id_ok  out  1  EID byte0 == 8'h0D and byte1 == 8'h5D.
- eid  out  64  EID; first received byte in [63:56].
- spiclk, mosi  out  1  SPI mode 0, MSB first.
- miso  in  1  device serial out.
- ce_q_  out  1  active-low chip select.

## Operation
- States: POR_WAIT → RSTEN → GAP → RST → GAP → RDID → GAP → IDLE → CMD → ADDR → DATA → (PAGE_GAP → CMD | END_GAP → IDLE).
- POR_WAIT: count POWERON_CYCLES with ce_q_ = 1 and spiclk = mosi = 0.
- RSTEN: one frame carrying 8'h66. RST: one frame carrying 8'h99.
- RDID: 8'h9F, then 3 address bytes of 8'h00, then 8 bytes captured into eid. Then init_done = 1 and id_ok is evaluated; a failed ID does not block operation.
- IDLE: req_ready = 1. Accept on req_valid && req_ready; latch write, addr, len.
- Frame: CMD byte (8'h02 write / 8'h03 read), then addr[23:0] big-endian (upper bits zero-extended), then data bytes.
- Write: wr_ready strobes once per byte, at the cycle the byte is loaded into the shifter. If wr_data is not ready, the requester must stall the request, not the strobe.
- Read: rd_valid pulses after the 8th rising spiclk edge of each data byte.
- Address: increments per data byte and wraps at 2^ADDR_W to 0.
- Page split: if addr[9:0] wraps to 0 with bytes remaining, release CE for CS_GAP cycles and reissue CMD with the new address. An address wrap to 0 is also a page wrap.
- done: pulses once per request, after the final frame's END_GAP.
- Reset mid-operation: on the next edge all outputs return to reset values and the FSM restarts from POR_WAIT. Any partial transfer is abandoned with no done.

## Timing
- Reset values: ce_q_ = 1; spiclk = mosi = 0; req_ready = wr_ready = rd_valid = done = init_done = id_ok = 0; eid = 0; rd_data = 0.
- spiclk idles low. mosi changes CLK_DIV cycles before each rising edge. miso is sampled at the rising edge.
- ce_q_ falls the cycle after accept. The first rising spiclk edge follows CLK_DIV cycles later.
- ce_q_ rises CLK_DIV cycles after the last falling edge.
- Byte n of a frame occupies 16·CLK_DIV cycles, back-to-back with no inter-byte gap.
- req_ready drops the cycle after acceptance and returns in the cycle done pulses.

## Structure
- Shared package psram_pkg: command constants (8'h02, 8'h03, 8'h66, 8'h99, 8'h9F), EID constants (8'h0D, 8'h5D), state enum, page size (1024).
- Sub-module psram_spi_byte: start/din/dout/busy/done byte shifter, parametrised by CLK_DIV. The controller FSM lives in the top.
- Target size: roughly 250 lines of RTL total.

## Test plan
- Power-up, model returns EID 0D 5D 11 22 33 44 55 66 → after POWERON_CYCLES: frames 66, 99, then 9F 00 00 00; eid = 64'h0D5D112233445566; id_ok = 1; init_done = 1.
- Write 4 bytes A0..A3 at 0x000100 → mosi stream 02 00 01 00 A0 A1 A2 A3 in one frame; 4 wr_ready strobes; one done.
- Read 4 bytes at 0x000100 → frame 03 00 01 00; rd_data sequence A0 A1 A2 A3; 4 rd_valid strobes.
- Write 4 bytes at 0x0003FE → two frames (02 00 03 FE + 2 bytes, then 02 00 04 00 + 2 bytes) with ce_q_ high ≥ CS_GAP cycles between them; one done.
- Read 2 bytes at 0x7FFFFF → frames at 0x7FFFFF and 0x000000.
- rst_n low during the 2nd data byte → ce_q_ = 1 on the next edge; no done; POR sequence repeats. Separately, EID byte0 = 8'h00 → id_ok = 0 with init_done = 1.
